// File: rtl/rf_wb_sched_if.sv
// Purpose : writeback / issue / register-file bundle for rf_wb_sched.
// Latency : n/a (signal bundle only).
// Backpr. : lu_valid_i/lu_ready_o handshake; stall_o holds the issue stage.
// Ports   : pipe_* (WB stage), lu_* (long-latency unit), iss_* (issue stage),
//           rf_* (register file write port), busy_o/err_o (debug/status).
interface rf_wb_sched_if #(
  parameter int REG_BITS  = 5,
  parameter int DATA_BITS = 32,
  parameter int REG_NUMS  = 32
);
  logic                 pipe_wr_i;
  logic [REG_BITS-1:0]  pipe_rd_i;
  logic [DATA_BITS-1:0] pipe_data_i;
  logic                 lu_valid_i;
  logic [REG_BITS-1:0]  lu_rd_i;
  logic [DATA_BITS-1:0] lu_data_i;
  logic                 lu_ready_o;
  logic                 iss_mark_i;
  logic [REG_BITS-1:0]  iss_rd_i;
  logic                 iss_use_rs1_i;
  logic                 iss_use_rs2_i;
  logic [REG_BITS-1:0]  iss_rs1_i;
  logic [REG_BITS-1:0]  iss_rs2_i;
  logic                 stall_o;
  logic                 rf_wr_o;
  logic [REG_BITS-1:0]  rf_rd_o;
  logic [DATA_BITS-1:0] rf_data_o;
  logic [REG_NUMS-1:0]  busy_o;
  logic                 err_o;

  // Driver side: WB stage, long-latency unit and issue stage.
  modport master (
    output pipe_wr_i, pipe_rd_i, pipe_data_i,
    output lu_valid_i, lu_rd_i, lu_data_i,
    input  lu_ready_o,
    output iss_mark_i, iss_rd_i, iss_use_rs1_i, iss_use_rs2_i, iss_rs1_i, iss_rs2_i,
    input  stall_o,
    input  rf_wr_o, rf_rd_o, rf_data_o,
    input  busy_o, err_o
  );

  // Scheduler side.
  modport slave (
    input  pipe_wr_i, pipe_rd_i, pipe_data_i,
    input  lu_valid_i, lu_rd_i, lu_data_i,
    output lu_ready_o,
    input  iss_mark_i, iss_rd_i, iss_use_rs1_i, iss_use_rs2_i, iss_rs1_i, iss_rs2_i,
    output stall_o,
    output rf_wr_o, rf_rd_o, rf_data_o,
    output busy_o, err_o
  );
endinterface

// File: rtl/rf_wb_sched.sv
// Purpose : merges pipeline WB and long-latency results onto the single RF
//           write port; per-register busy scoreboard drives the issue stall.
// Latency : pipe write 0 cycles (combinational to rf_*); LU result >=1 cycle
//           after push (registered FIFO, no bypass), +1 per competing pipe write.
// Backpr. : lu_ready_o low while the FIFO is full (registered count only);
//           stall_o holds issue on RAW/WAW against a pending LU result.
// Ports   : clk, rst (async, active-high), bus (rf_wb_sched_if.slave).
module rf_wb_sched #(
  parameter int REG_BITS  = 5,
  parameter int DATA_BITS = 32,
  parameter int REG_NUMS  = 32,
  parameter int LU_DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  rf_wb_sched_if.slave bus
);
  localparam int PTR_BITS = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int CNT_BITS = $clog2(LU_DEPTH + 1);
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(LU_DEPTH);

  logic [REG_BITS-1:0]  rd_mem   [LU_DEPTH];
  logic [DATA_BITS-1:0] data_mem [LU_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0]  count;
  logic [REG_NUMS-1:0]  busy_q, busy_d;
  logic                 err_q;

  logic                 push, pop, fifo_ne;
  logic [REG_BITS-1:0]  head_rd;
  logic [DATA_BITS-1:0] head_data;
  logic                 stall, mark_set, head_clr, err_set;

  assign fifo_ne   = (count != '0);
  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Ready comes purely from registered count: a pop this cycle does not
  // open a slot until the next cycle.
  assign bus.lu_ready_o = (count < DEPTH_C);
  assign push = bus.lu_valid_i && bus.lu_ready_o;
  // The pipeline owns the port whenever it writes, even to x0.
  assign pop  = !bus.pipe_wr_i && fifo_ne;

  // The mark term keeps a register from being marked twice, which is what
  // guarantees set and clear never target the same bit in one cycle.
  assign stall = (bus.iss_use_rs1_i && busy_q[bus.iss_rs1_i]) ||
                 (bus.iss_use_rs2_i && busy_q[bus.iss_rs2_i]) ||
                 (bus.iss_mark_i    && busy_q[bus.iss_rd_i]);
  assign bus.stall_o = stall;

  assign mark_set = bus.iss_mark_i && !stall && (bus.iss_rd_i != '0);
  assign head_clr = pop && (head_rd != '0);

  assign err_set = (bus.pipe_wr_i && (bus.pipe_rd_i != '0) && busy_q[bus.pipe_rd_i]) ||
                   (push && (bus.lu_rd_i != '0) && !busy_q[bus.lu_rd_i]);

  // Write port mux; rf_wr_o is gated by rst because pipe_wr_i is a live input.
  always_comb begin
    bus.rf_wr_o   = 1'b0;
    bus.rf_rd_o   = '0;
    bus.rf_data_o = '0;
    if (bus.pipe_wr_i) begin
      bus.rf_wr_o   = !rst && (bus.pipe_rd_i != '0);
      bus.rf_rd_o   = bus.pipe_rd_i;
      bus.rf_data_o = bus.pipe_data_i;
    end else if (fifo_ne) begin
      bus.rf_wr_o   = !rst && (head_rd != '0);
      bus.rf_rd_o   = head_rd;
      bus.rf_data_o = head_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (head_clr) busy_d[head_rd] = 1'b0;
    if (mark_set) busy_d[bus.iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // FIFO storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= bus.lu_rd_i;
      data_mem[wr_ptr] <= bus.lu_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      busy_q <= busy_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.err_o  = err_q;
endmodule

// File: tb/tb_rf_wb_sched.sv
// Purpose : directed self-checking bench for rf_wb_sched.
// Latency : inputs change 1 time unit after posedge; checks 1 unit later.
// Backpr. : n/a (bench drives lu_valid_i and observes lu_ready_o).
module tb_rf_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rf_wb_sched_if #(.REG_BITS(5), .DATA_BITS(32), .REG_NUMS(32)) bus ();

  rf_wb_sched #(.REG_BITS(5), .DATA_BITS(32), .REG_NUMS(32), .LU_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.pipe_wr_i = 0; bus.pipe_rd_i = 0; bus.pipe_data_i = 0;
    bus.lu_valid_i = 0; bus.lu_rd_i = 0; bus.lu_data_i = 0;
    bus.iss_mark_i = 0; bus.iss_rd_i = 0;
    bus.iss_use_rs1_i = 0; bus.iss_use_rs2_i = 0;
    bus.iss_rs1_i = 0; bus.iss_rs2_i = 0;
  endtask

  // Advance past the next edge, then return all inputs to idle.
  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
    bus.pipe_wr_i = 1; bus.pipe_rd_i = rd; bus.pipe_data_i = d;
  endtask

  task automatic lu(input logic [4:0] rd, input logic [31:0] d);
    bus.lu_valid_i = 1; bus.lu_rd_i = rd; bus.lu_data_i = d;
  endtask

  task automatic mark(input logic [4:0] rd);
    bus.iss_mark_i = 1; bus.iss_rd_i = rd;
  endtask

  task automatic do_reset();
    rst = 1; idle(); settle();
    step(); rst = 0; settle();
  endtask

  initial begin
    #20000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "bench timeout");
  end

  initial begin
    // ---- reset state, pipe write present while rst high ----
    idle(); pipe(3, 32'h1); settle();
    check("rst_rf_wr",  bus.rf_wr_o, 0);
    check("rst_ready",  bus.lu_ready_o, 1);
    check("rst_busy",   bus.busy_o, 0);
    check("rst_err",    bus.err_o, 0);
    check("rst_stall",  bus.stall_o, 0);
    step(); step(); rst = 0; settle();

    // ---- priority: pipe writes delay a buffered LU result ----
    mark(7); settle();
    check("pri_mark_nostall", bus.stall_o, 0);
    step();
    check("pri_busy7", bus.busy_o, 32'h80);
    lu(7, 32'hAAAA_0001); settle();
    check("pri_ready", bus.lu_ready_o, 1);
    step();
    pipe(3, 32'h11); settle();
    check("pri_w1_rd",   bus.rf_rd_o, 3);
    check("pri_w1_data", bus.rf_data_o, 32'h11);
    check("pri_w1_wr",   bus.rf_wr_o, 1);
    step();
    pipe(4, 32'h22); settle();
    check("pri_w2_rd",   bus.rf_rd_o, 4);
    check("pri_w2_data", bus.rf_data_o, 32'h22);
    step(); settle();
    check("pri_w3_wr",   bus.rf_wr_o, 1);
    check("pri_w3_rd",   bus.rf_rd_o, 7);
    check("pri_w3_data", bus.rf_data_o, 32'hAAAA_0001);
    check("pri_busy_before_clr", bus.busy_o, 32'h80);
    step(); settle();
    check("pri_busy_clr", bus.busy_o, 0);
    check("pri_idle_wr",  bus.rf_wr_o, 0);
    check("pri_err",      bus.err_o, 0);

    // ---- RAW stall; concurrent mark of x10 held off ----
    mark(9); step();
    bus.iss_use_rs1_i = 1; bus.iss_rs1_i = 9; mark(10); settle();
    check("raw_stall1", bus.stall_o, 1);
    step();
    check("raw_no_mark10", bus.busy_o, 32'h200);
    bus.iss_use_rs1_i = 1; bus.iss_rs1_i = 9; mark(10);
    lu(9, 32'h99); settle();
    check("raw_stall2", bus.stall_o, 1);
    step();
    bus.iss_use_rs1_i = 1; bus.iss_rs1_i = 9; mark(10); settle();
    check("raw_stall3", bus.stall_o, 1);
    check("raw_commit_rd", bus.rf_rd_o, 9);
    check("raw_commit_wr", bus.rf_wr_o, 1);
    step();
    bus.iss_use_rs1_i = 1; bus.iss_rs1_i = 9; mark(10); settle();
    check("raw_released", bus.stall_o, 0);
    step();
    check("raw_mark10", bus.busy_o, 32'h400);

    // ---- FIFO full, backpressure, drain with wrap ----
    do_reset();
    check("rst_busy_clear", bus.busy_o, 0);
    for (int r = 1; r <= 4; r++) begin
      mark(5'(r)); step();
    end
    check("full_busy", bus.busy_o, 32'h1E);
    pipe(20, 32'h20); lu(1, 32'h101); step();
    pipe(20, 32'h20); lu(2, 32'h102); step();
    pipe(20, 32'h20); lu(3, 32'h103); settle();
    check("full_not_ready", bus.lu_ready_o, 0);
    step();
    pipe(20, 32'h20); lu(3, 32'h103); settle();
    check("full_still_not_ready", bus.lu_ready_o, 0);
    step();
    lu(3, 32'h103); settle();
    check("drain1_rd",    bus.rf_rd_o, 1);
    check("drain1_data",  bus.rf_data_o, 32'h101);
    check("drain1_noready", bus.lu_ready_o, 0);
    step();
    lu(3, 32'h103); settle();
    check("drain2_rd",    bus.rf_rd_o, 2);
    check("drain2_data",  bus.rf_data_o, 32'h102);
    check("drain2_ready", bus.lu_ready_o, 1);
    step();
    lu(4, 32'h104); settle();
    check("drain3_rd",    bus.rf_rd_o, 3);
    check("drain3_data",  bus.rf_data_o, 32'h103);
    check("pushpop_ready", bus.lu_ready_o, 1);
    step(); settle();
    check("drain4_rd",    bus.rf_rd_o, 4);
    check("drain4_data",  bus.rf_data_o, 32'h104);
    step(); settle();
    check("drain_empty_wr", bus.rf_wr_o, 0);
    check("drain_busy",   bus.busy_o, 0);
    check("drain_err",    bus.err_o, 0);

    // ---- rd=0 result popped without a write ----
    lu(0, 32'h55); step(); settle();
    check("x0_pop_wr",   bus.rf_wr_o, 0);
    check("x0_pop_data", bus.rf_data_o, 32'h55);
    step(); settle();
    check("x0_after_data", bus.rf_data_o, 0);
    check("x0_err", bus.err_o, 0);

    // ---- x0 mark/write, then WAW error ----
    mark(0); step();
    check("x0_mark_busy", bus.busy_o, 0);
    pipe(0, 32'h5); settle();
    check("x0_pipe_wr", bus.rf_wr_o, 0);
    step();
    check("x0_no_err", bus.err_o, 0);
    mark(12); step();
    pipe(12, 32'hC); settle();
    check("waw_write_proceeds", bus.rf_wr_o, 1);
    step();
    check("waw_err", bus.err_o, 1);
    step(); step(); settle();
    check("waw_err_sticky", bus.err_o, 1);

    // ---- push to non-busy register in a fresh run ----
    do_reset();
    check("fresh_err0", bus.err_o, 0);
    lu(13, 32'hD); step();
    check("nobusy_push_err", bus.err_o, 1);

    // ---- reset mid-traffic with two buffered results ----
    do_reset();
    mark(5); step();
    mark(6); step();
    pipe(20, 32'h1); lu(5, 32'h5); step();
    pipe(20, 32'h1); lu(6, 32'h6); step();
    pipe(20, 32'h1); settle();
    check("mid_full", bus.lu_ready_o, 0);
    check("mid_busy", bus.busy_o, 32'h60);
    rst = 1; settle();
    check("mid_rst_wr",    bus.rf_wr_o, 0);
    check("mid_rst_ready", bus.lu_ready_o, 1);
    check("mid_rst_busy",  bus.busy_o, 0);
    check("mid_rst_err",   bus.err_o, 0);
    step(); rst = 0; settle();
    check("mid_discarded", bus.rf_wr_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Write-port scheduler and scoreboard for the CPU integer register file. It merges two writeback sources onto the file's single write port: the in-order pipeline WB stage (fixed slot, cannot stall) and the long-latency unit (load/mul-div, valid/ready). The lower-priority source is buffered in a small FIFO. A per-register busy scoreboard generates the issue-stage stall for RAW/WAW hazards on pending long-latency results. It sits between WB, the long-latency unit, the issue stage and the register file write port.

## Interface
- REG_BITS, 5, register address width
- DATA_BITS, 32, data width
- REG_NUMS, 32, number of architectural registers
- LU_DEPTH, 2, long-latency result FIFO depth (power of two, ≥2)

- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- pipe_wr_i  input  1  pipeline WB write request
- pipe_rd_i  input  REG_BITS  pipeline WB destination
- pipe_data_i  input  DATA_BITS  pipeline WB data
- lu_valid_i  input  1  long-latency result valid
- lu_rd_i  input  REG_BITS  long-latency destination
- lu_data_i  input  DATA_BITS  long-latency data
- lu_ready_o  output  1  FIFO can accept a result
- iss_mark_i  input  1  issue stage dispatches a long-latency op writing iss_rd_i
- iss_rd_i  input  REG_BITS  destination of issuing op
- iss_use_rs1_i, iss_use_rs2_i  input  1 each  issuing instruction reads rs1/rs2
- iss_rs1_i, iss_rs2_i  input  REG_BITS each  source registers of issuing instruction
- stall_o  output  1  issue must hold this cycle
- rf_wr_o  output  1  register file write enable
- rf_rd_o  output  REG_BITS  register file write address
- rf_data_o  output  DATA_BITS  register file write data
- busy_o  output  REG_NUMS  scoreboard vector (debug)
- err_o  output  1  sticky protocol error

## Operation
- Write-port priority: pipe_wr_i always wins. If pipe_wr_i=1: rf_wr_o=(pipe_rd_i≠0), rf_rd_o/rf_data_o=pipe fields, no FIFO pop. Else, if FIFO non-empty: pop head, rf_wr_o=(head.rd≠0), outputs=head fields. Else rf_wr_o=0 and rf_rd_o/rf_data_o=0.
- FIFO: LU_DEPTH entries of {rd, data}, read/write pointers wrapping modulo LU_DEPTH, count 0..LU_DEPTH. Push when lu_valid_i && lu_ready_o. lu_ready_o = (count<LU_DEPTH), from registered state only, with no same-cycle pop pass-through. Push and pop in the same cycle leave count unchanged. Entries with rd=0 are popped in a free slot without writing.
- Scoreboard: busy[REG_NUMS-1:0]; busy[0] is always 0.
  - Set: busy[iss_rd_i] at the edge when iss_mark_i && !stall_o && iss_rd_i≠0.
  - Clear: busy[head.rd] at the edge when that head is popped and written.
  - Set and clear of different registers in the same cycle both apply.
- stall_o is combinational from registered busy:
  - (iss_use_rs1_i && busy[iss_rs1_i]) || (iss_use_rs2_i && busy[iss_rs2_i]) || (iss_mark_i && busy[iss_rd_i]).
  - Because of the last term, a register is never marked twice, so set/clear of the same register in one cycle cannot occur.
- err_o is set, and held until reset, on any of:
  - pipe_wr_i with pipe_rd_i≠0 and busy[pipe_rd_i] (WAW over a pending result);
  - a FIFO push whose lu_rd_i≠0 has busy[lu_rd_i]=0;
  - lu_valid_i && !lu_ready_o held for more than 64 consecutive cycles is **not** an error; it is backpressure.
- Detected errors have no other effect: the write still proceeds.

## Timing
- Reset (asynchronous, immediate): FIFO empty, pointers/count 0, busy all 0, err_o=0, lu_ready_o=1, stall_o=0, rf_wr_o=0 (forced 0 while rst high, even if pipe_wr_i=1).
- Reset mid-operation discards buffered FIFO results and pending busy marks. Issue and the long-latency unit are reset by the same rst.
- Pipeline write latency 0: rf_* mirror pipe inputs in the same cycle, and the register file captures them at the next edge.
- Long-latency result: pushed at edge N. Earliest write slot is cycle N+1 (FIFO registered, no bypass). It is delayed one cycle per pipe write.
- busy clears at the edge that commits the write. Readers stalled on that register see stall_o=0 in the following cycle, when the register file already holds the new value. No forwarding is required.
- A full FIFO with continuous pipe writes starves the FIFO. The pipeline must leave gaps; this is a system guarantee, not checked here.

## Test plan
- Reset mid-traffic: FIFO holding 2 entries, busy[5]=1, assert rst -> rf_wr_o=0 immediately, lu_ready_o=1, busy_o=0, err_o=0.
- Priority: mark x7, push {7, 0xAAAA_0001}, then pipe writes x3=0x11, x4=0x22 on the next two cycles -> rf writes x3, x4, then x7=0xAAAA_0001; busy[7] clears after the x7 write.
- RAW stall: mark x9, next cycle iss_use_rs1_i with rs1=9 -> stall_o=1 until the cycle after x9 commits, then 0. A concurrent mark of x10 is held off while stalled.
- FIFO full/wrap: mark x1..x4, pipe_wr_i held high, push 2 results -> lu_ready_o=0. Drop pipe_wr_i -> entries drain in order, push x3,x4 after space frees; pointers wrap, data order preserved.
- Simultaneous push+pop at count=1 -> count stays 1, lu_ready_o stays 1. A result with rd=0 is popped with rf_wr_o=0.
- Errors: pipe write to busy x12 -> err_o=1 and sticky. Push to non-busy x13 in a fresh run -> err_o=1. x0 mark/write -> busy_o[0]=0, no error.
